// File: rtl/pid_pkg.sv
// Shared constants and arithmetic helpers for the pipelined heading PID.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pid_pkg;

  // Default widths and gains
  localparam int DEF_ERR_W     = 12;
  localparam int DEF_SAT_W     = 10;
  localparam int DEF_FWD_W     = 10;
  localparam int DEF_SPD_W     = 11;
  localparam int DEF_I_W       = 15;
  localparam int DEF_I_SHIFT   = 6;
  localparam int DEF_D_DEPTH   = 2;
  localparam int DEF_D_SAT_W   = 7;
  localparam int DEF_P_COEFF   = 8;
  localparam int DEF_D_COEFF   = 11;
  localparam int DEF_OUT_SHIFT = 3;
  localparam int DEF_SLEW_MAX  = 0;

  // Internal arithmetic width; wide enough that no PID intermediate can overflow
  localparam int CALC_W = 32;

  // Clamp a signed value into the range of a w-bit signed number
  function automatic logic signed [CALC_W-1:0] sat_s(input logic signed [CALC_W-1:0] v,
                                                     input int w);
    logic signed [CALC_W-1:0] hi;
    logic signed [CALC_W-1:0] lo;
    hi = (CALC_W'(1) <<< (w - 1)) - 1;
    lo = -hi - 1;
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
  endfunction

  // Treat the low w bits of v as a signed number and sign-extend to CALC_W
  function automatic logic signed [CALC_W-1:0] sext(input logic [CALC_W-1:0] v,
                                                    input int w);
    logic [CALC_W-1:0] t;
    t = v << (CALC_W - w);
    return $signed(t) >>> (CALC_W - w);
  endfunction

endpackage

// File: rtl/pid_ctrl_pipe_slew.sv
// Per-wheel slew-rate limiter: steps the registered output toward target by at most SLEW_MAX.
// Latency: output updates on the edge where ld is high; clr zeroes it on the next edge.
// Backpressure: none; ld is a strobe and every load is accepted.
module slew_limiter
  import pid_pkg::*;
#(
  parameter int SPD_W    = DEF_SPD_W,
  parameter int SLEW_MAX = DEF_SLEW_MAX
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             ld,
  input  logic [SPD_W-1:0] target,
  output logic [SPD_W-1:0] out
);

  logic signed [CALC_W-1:0] t_x;
  logic signed [CALC_W-1:0] c_x;
  logic signed [CALC_W-1:0] diff;
  logic        [SPD_W-1:0]  nxt;

  // Pick the next output: jump straight to target when close enough or bypassed
  always_comb begin
    t_x  = sext(CALC_W'(target), SPD_W);
    c_x  = sext(CALC_W'(out), SPD_W);
    diff = t_x - c_x;
    nxt  = target;
    if (SLEW_MAX != 0) begin
      if (diff > SLEW_MAX)       nxt = SPD_W'(c_x + SLEW_MAX);
      else if (diff < -SLEW_MAX) nxt = SPD_W'(c_x - SLEW_MAX);
    end
  end

  // Output register; clear has priority over load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  out <= '0;
    else if (clr) out <= '0;
    else if (ld)  out <= nxt;
  end

endmodule

// File: rtl/pid_ctrl_pipe.sv
// Three-stage heading PID: error saturate, P/I/D sum with anti-windup, wheel mix + slew limit.
// Latency: err_vld at edge N gives spd_vld high after edge N+2; full throughput.
// Backpressure: none; every qualified err_vld yields one spd_vld unless moving drops first.
module pid_ctrl_pipe
  import pid_pkg::*;
#(
  parameter int ERR_W     = DEF_ERR_W,
  parameter int SAT_W     = DEF_SAT_W,
  parameter int FWD_W     = DEF_FWD_W,
  parameter int SPD_W     = DEF_SPD_W,
  parameter int I_W       = DEF_I_W,
  parameter int I_SHIFT   = DEF_I_SHIFT,
  parameter int D_DEPTH   = DEF_D_DEPTH,
  parameter int D_SAT_W   = DEF_D_SAT_W,
  parameter int P_COEFF   = DEF_P_COEFF,
  parameter int D_COEFF   = DEF_D_COEFF,
  parameter int OUT_SHIFT = DEF_OUT_SHIFT,
  parameter int SLEW_MAX  = DEF_SLEW_MAX
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             moving,
  input  logic             err_vld,
  input  logic [ERR_W-1:0] error,
  input  logic [FWD_W-1:0] frwrd,
  output logic [SPD_W-1:0] lft_spd,
  output logic [SPD_W-1:0] rght_spd,
  output logic             spd_vld,
  output logic             clamp
);

  // Stage 0 state
  logic [SAT_W-1:0] err_q;
  logic             v1;

  // Stage 1 state
  logic [I_W-1:0]           integ;
  logic [SAT_W-1:0]         hist [D_DEPTH];
  logic signed [CALC_W-1:0] pid_q;
  logic                     v2;

  // Stage 1 combinational terms
  logic signed [CALC_W-1:0] err_x;
  logic signed [CALC_W-1:0] integ_x;
  logic signed [CALC_W-1:0] hist_x;
  logic signed [CALC_W-1:0] p_term;
  logic signed [CALC_W-1:0] i_term;
  logic signed [CALC_W-1:0] d_term;
  logic signed [CALC_W-1:0] pid_d;
  logic signed [CALC_W-1:0] integ_sum;
  logic                     integ_ovf;
  logic                     integ_hold;

  // Stage 2 combinational terms
  logic signed [CALC_W-1:0] sh;
  logic signed [CALC_W-1:0] fw_x;
  logic signed [CALC_W-1:0] tl_full;
  logic signed [CALC_W-1:0] tr_full;
  logic signed [CALC_W-1:0] tl_sat;
  logic signed [CALC_W-1:0] tr_sat;
  logic                     sat_any;
  logic [SPD_W-1:0]         tgt_l;
  logic [SPD_W-1:0]         tgt_r;
  logic                     slew_ld;

  // Stage 0: capture the saturated error and launch the sample while driving
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
      v1    <= 1'b0;
    end else begin
      v1 <= err_vld & moving;
      if (err_vld & moving)
        err_q <= SAT_W'(sat_s(sext(CALC_W'(error), ERR_W), SAT_W));
    end
  end

  // Stage 1 terms: P, I from the pre-update integrator, D against the oldest history tap
  always_comb begin
    err_x     = sext(CALC_W'(err_q), SAT_W);
    integ_x   = sext(CALC_W'(integ), I_W);
    hist_x    = sext(CALC_W'(hist[D_DEPTH-1]), SAT_W);
    p_term    = err_x * P_COEFF;
    i_term    = integ_x >>> I_SHIFT;
    d_term    = sat_s(err_x - hist_x, D_SAT_W) * D_COEFF;
    pid_d     = p_term + i_term + d_term;
    integ_sum = integ_x + err_x;
    integ_ovf = (sat_s(integ_sum, I_W) != integ_sum);
    // Anti-windup: stop pushing the integrator further in the direction that is saturating
    integ_hold = integ_ovf | (clamp & (err_q[SAT_W-1] == integ[I_W-1]));
  end

  // Stage 1 registers: PID sum, integrator and derivative history; moving low wipes them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      integ <= '0;
      pid_q <= '0;
      v2    <= 1'b0;
      for (int k = 0; k < D_DEPTH; k++) hist[k] <= '0;
    end else if (!moving) begin
      integ <= '0;
      v2    <= 1'b0;
      for (int k = 0; k < D_DEPTH; k++) hist[k] <= '0;
    end else begin
      v2 <= v1;
      if (v1) begin
        pid_q <= pid_d;
        if (!integ_hold) integ <= I_W'(integ_sum);
        hist[0] <= err_q;
        for (int k = 1; k < D_DEPTH; k++) hist[k] <= hist[k-1];
      end
    end
  end

  // Stage 2 mix: wide add/sub makes the saturation test exact regardless of sum magnitude
  always_comb begin
    sh      = pid_q >>> OUT_SHIFT;
    fw_x    = $signed(CALC_W'(frwrd));
    tl_full = fw_x + sh;
    tr_full = fw_x - sh;
    tl_sat  = sat_s(tl_full, SPD_W);
    tr_sat  = sat_s(tr_full, SPD_W);
    sat_any = (tl_sat != tl_full) | (tr_sat != tr_full);
    tgt_l   = SPD_W'(tl_sat);
    tgt_r   = SPD_W'(tr_sat);
    slew_ld = v2 & moving;
  end

  // Stage 2 flags: one-cycle valid strobe and sticky-until-next-update clamp
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spd_vld <= 1'b0;
      clamp   <= 1'b0;
    end else if (!moving) begin
      spd_vld <= 1'b0;
      clamp   <= 1'b0;
    end else begin
      spd_vld <= v2;
      if (v2) clamp <= sat_any;
    end
  end

  slew_limiter #(
    .SPD_W   (SPD_W),
    .SLEW_MAX(SLEW_MAX)
  ) u_slew_l (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!moving),
    .ld    (slew_ld),
    .target(tgt_l),
    .out   (lft_spd)
  );

  slew_limiter #(
    .SPD_W   (SPD_W),
    .SLEW_MAX(SLEW_MAX)
  ) u_slew_r (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!moving),
    .ld    (slew_ld),
    .target(tgt_r),
    .out   (rght_spd)
  );

endmodule

// File: tb/tb_pid_ctrl_pipe.sv
// Bench for pid_ctrl_pipe: one unlimited instance and one SLEW_MAX=64 instance share stimulus.
// Latency: expectations are queued at drive time and retired on spd_vld.
// Backpressure: n/a.
module tb_pid_ctrl_pipe;

  logic        clk;
  logic        rst_n;
  logic        moving;
  logic        err_vld;
  logic [11:0] error;
  logic [9:0]  frwrd;
  logic [10:0] l0, r0, l1, r1;
  logic        v0, vs1, c0, c1;

  typedef struct {int l0; int r0; int l1; int r1; bit c;} exp_t;
  typedef struct {logic [11:0] err; logic [9:0] fw; int l; int r; bit c;} vec_t;

  exp_t sbq[$];
  vec_t vecs[10];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Bench-side state: previous slewed outputs and a sample-level PID model
  int p1l, p1r;
  int m_integ, m_h0, m_h1;
  bit m_clamp;

  pid_ctrl_pipe dut0 (
    .clk(clk), .rst_n(rst_n), .moving(moving), .err_vld(err_vld), .error(error),
    .frwrd(frwrd), .lft_spd(l0), .rght_spd(r0), .spd_vld(v0), .clamp(c0)
  );

  pid_ctrl_pipe #(.SLEW_MAX(64)) dut1 (
    .clk(clk), .rst_n(rst_n), .moving(moving), .err_vld(err_vld), .error(error),
    .frwrd(frwrd), .lft_spd(l1), .rght_spd(r1), .spd_vld(vs1), .clamp(c1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int hi;
    hi = (1 << (w - 1)) - 1;
    if (v > hi) return hi;
    if (v < -hi - 1) return -hi - 1;
    return v;
  endfunction

  function automatic int slew(input int cur, input int t, input int m);
    if (t - cur > m) return cur + m;
    if (cur - t > m) return cur - m;
    return t;
  endfunction

  task automatic bench_clear();
    p1l = 0; p1r = 0;
    m_integ = 0; m_h0 = 0; m_h1 = 0; m_clamp = 0;
  endtask

  // Queue an expectation given unlimited-instance targets; derive the slewed instance
  task automatic push(input int l, input int r, input bit c);
    exp_t e;
    e.l0 = l; e.r0 = r; e.c = c;
    e.l1 = slew(p1l, l, 64);
    e.r1 = slew(p1r, r, 64);
    p1l = e.l1; p1r = e.r1;
    sbq.push_back(e);
  endtask

  // Sample-level reference: default gains, samples not interleaved with clamp changes
  task automatic model_push(input int es, input int fw);
    int p, i, d, pid, s, sh, tl, tr;
    bit c;
    p   = es * 8;
    i   = m_integ >>> 6;
    d   = sat(es - m_h1, 7) * 11;
    pid = p + i + d;
    s   = m_integ + es;
    if (s <= 16383 && s >= -16384 && !(m_clamp && ((es < 0) == (m_integ < 0))))
      m_integ = s;
    m_h1 = m_h0; m_h0 = es;
    sh = pid >>> 3;
    tl = sat(fw + sh, 11);
    tr = sat(fw - sh, 11);
    c  = (tl != fw + sh) || (tr != fw - sh);
    m_clamp = c;
    push(tl, tr, c);
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (sbq.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    n_tests++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d results outstanding, expected 0", name, sbq.size());
      sbq.delete();
    end
  endtask

  // Scoreboard: retire one expectation per spd_vld from either instance
  always @(negedge clk) begin
    if (v0 || vs1) begin
      if (sbq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_spd_vld: vld0=%0b vld1=%0b lft=%0d, expected no output",
                 v0, vs1, $signed(l0));
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("vld0", int'(v0), 1);
        chk("vld1", int'(vs1), 1);
        chk("lft0", $signed(l0), e.l0);
        chk("rght0", $signed(r0), e.r0);
        chk("clamp0", int'(c0), int'(e.c));
        chk("lft1", $signed(l1), e.l1);
        chk("rght1", $signed(r1), e.r1);
        chk("clamp1", int'(c1), int'(e.c));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Isolated samples from a fresh reset; expected values worked by hand
    vecs[0] = '{12'h7FF, 10'h100,  853, -341, 1'b0};
    vecs[1] = '{12'h800, 10'h100, -344,  856, 1'b0};
    vecs[2] = '{12'h000, 10'h100,  167,  345, 1'b0};
    vecs[3] = '{12'h000, 10'h100,  342,  170, 1'b0};
    vecs[4] = '{12'h000, 10'h100,  255,  257, 1'b0};
    vecs[5] = '{12'h7FF, 10'h3FF, 1023,  426, 1'b1};
    vecs[6] = '{12'h7FF, 10'h3FF, 1023,  425, 1'b1};
    vecs[7] = '{12'h7FF, 10'h3FF, 1023,  512, 1'b1};
    vecs[8] = '{12'hF9C, 10'h3FF,  835, 1023, 1'b1};
    vecs[9] = '{12'hF9C, 10'h3FF,  835, 1023, 1'b1};

    clk = 0; rst_n = 0; moving = 0; err_vld = 0; error = '0; frwrd = '0;
    bench_clear();
    repeat (2) @(negedge clk);
    chk("rst_lft", $signed(l0), 0);
    chk("rst_rght", $signed(r0), 0);
    chk("rst_vld", int'(v0), 0);
    chk("rst_clamp", int'(c0), 0);
    chk("rst_lft1", $signed(l1), 0);
    rst_n = 1; moving = 1;
    @(negedge clk);

    // Table vectors, spaced so each sees the previous clamp
    for (int k = 0; k < 10; k++) begin
      push(vecs[k].l, vecs[k].r, vecs[k].c);
      err_vld = 1; error = vecs[k].err; frwrd = vecs[k].fw;
      @(negedge clk);
      err_vld = 0;
      repeat (3) @(negedge clk);
    end
    drain("table");

    // Drop moving with a sample in flight: it must vanish and outputs clear
    err_vld = 1; error = 12'h7FF; frwrd = 10'h100;
    @(negedge clk);
    err_vld = 0; moving = 0;
    @(negedge clk);
    chk("drop_lft", $signed(l0), 0);
    chk("drop_rght", $signed(r0), 0);
    chk("drop_clamp", int'(c0), 0);
    chk("drop_lft1", $signed(l1), 0);
    err_vld = 1;
    repeat (3) @(negedge clk);
    err_vld = 0; moving = 1;
    bench_clear();

    // Back-to-back samples driving the integrator into its overflow hold
    frwrd = 10'h100; error = 12'h1FF;
    for (int k = 0; k < 40; k++) begin
      model_push(511, 256);
      err_vld = 1;
      @(negedge clk);
    end
    err_vld = 0;
    drain("integ");

    moving = 0;
    repeat (2) @(negedge clk);
    moving = 1;
    bench_clear();

    // Constant target 853 from rest: the limited instance ramps in steps of 64
    frwrd = 10'd853; error = '0;
    for (int k = 0; k < 14; k++) begin
      exp_t e;
      e.l0 = 853; e.r0 = 853; e.c = 1'b0;
      e.l1 = (k < 13) ? 64 * (k + 1) : 853;
      e.r1 = e.l1;
      sbq.push_back(e);
      err_vld = 1;
      @(negedge clk);
    end
    err_vld = 0;
    drain("slew");

    // Asynchronous reset with samples in flight
    err_vld = 1; error = 12'h100;
    @(negedge clk);
    @(negedge clk);
    err_vld = 0;
    #2 rst_n = 0;
    #1;
    chk("arst_lft", $signed(l0), 0);
    chk("arst_rght", $signed(r0), 0);
    chk("arst_lft1", $signed(l1), 0);
    chk("arst_vld", int'(v0), 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (5) @(negedge clk);
    chk("post_arst_lft", $signed(l0), 0);
    chk("post_arst_rght1", $signed(r1), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
